mac_matrix_mem: RTL

Matrix storage and sequencing block for the pipelined MAC path. It accepts matrices A (param_M×param_K) and B (param_K×param_N) as a single host stream, serves synchronous one-cycle-latency reads to the MAC unit while it holds `mac_compute` high, and captures the MAC unit's C (param_M×param_N) write-backs. After the MAC unit signals completion, it drains C to the host as a valid/ready stream.

---
 rtl/mac_matrix_mem.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mac_matrix_mem.sv
// mac_matrix_mem
// Matrix storage and sequencing for the pipelined MAC path. The host streams
// A (row-major) then B (row-major). On start, the MAC unit reads A/B through
// one-cycle-latency registered ports and writes C back. After mac_done, C is
// drained to the host row-major over a valid/ready stream.
//
// Ports
//   clk, rstn                 clock, async active-low reset
//   load_valid/ready/data     host A/B input stream
//   start                     begin compute (READY only)
//   mac_compute               MAC unit enable
//   a_b_re, a_addr_in,
//   b_addr_in                 MAC read request (served in every state)
//   a_data_out, b_data_out    registered read data
//   c_we, c_addr_in,
//   c_data_in                 C write-back (COMPUTE only)
//   mac_done                  MAC unit finished (COMPUTE only)
//   out_valid/ready/data      C output stream
//   drain_done                pulse in the cycle after the last C transfer
//
// state   | meaning
// --------+----------------------------------------------
// LOAD    | accepting A then B from the host
// READY   | matrices loaded, waiting for start
// COMPUTE | MAC unit owns the read and C write ports
// DRAIN   | streaming C to the host
module mac_matrix_mem #(
  parameter int param_M            = 4,
  parameter int param_K            = 4,
  parameter int param_N            = 4,
  parameter int DATA_WIDTH_INITIAL = 8,
  parameter int DATA_WIDTH_FINAL   = DATA_WIDTH_INITIAL * 2,
  localparam int AW = $clog2(param_M * param_K),
  localparam int BW = $clog2(param_K * param_N),
  localparam int CW = $clog2(param_M * param_N)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [DATA_WIDTH_INITIAL-1:0] load_data,
  input  logic                          start,
  output logic                          mac_compute,
  input  logic                          a_b_re,
  input  logic [AW-1:0]                 a_addr_in,
  input  logic [BW-1:0]                 b_addr_in,
  output logic [DATA_WIDTH_INITIAL-1:0] a_data_out,
  output logic [DATA_WIDTH_INITIAL-1:0] b_data_out,
  input  logic                          c_we,
  input  logic [CW-1:0]                 c_addr_in,
  input  logic [DATA_WIDTH_FINAL-1:0]   c_data_in,
  input  logic                          mac_done,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH_FINAL-1:0]   out_data,
  output logic                          drain_done
);

  localparam int A_SZ = param_M * param_K;
  localparam int B_SZ = param_K * param_N;
  localparam int C_SZ = param_M * param_N;
  localparam int TOT  = A_SZ + B_SZ;
  localparam int LW   = $clog2(TOT);

  localparam logic [AW:0]   A_LIM   = A_SZ[AW:0];
  localparam logic [BW:0]   B_LIM   = B_SZ[BW:0];
  localparam logic [CW:0]   C_LIM   = C_SZ[CW:0];
  localparam logic [LW-1:0] LD_A    = A_SZ[LW-1:0];
  localparam logic [LW-1:0] LD_LAST = LW'(TOT - 1);
  localparam logic [CW-1:0] DR_LAST = CW'(C_SZ - 1);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    READY   = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [LW-1:0]                 ld_idx_q, ld_idx_d;
  logic [CW-1:0]                 dr_idx_q, dr_idx_d;
  logic                          drain_done_q, drain_done_d;
  logic [DATA_WIDTH_INITIAL-1:0] a_data_q, b_data_q;

  logic [DATA_WIDTH_INITIAL-1:0] a_mem [A_SZ];
  logic [DATA_WIDTH_INITIAL-1:0] b_mem [B_SZ];
  logic [DATA_WIDTH_FINAL-1:0]   c_mem [C_SZ];

  logic [AW-1:0] ld_a_idx;
  logic [BW-1:0] ld_b_idx;
  logic          a_in_rng, b_in_rng, c_in_rng;

  assign ld_a_idx = AW'(ld_idx_q);
  assign ld_b_idx = BW'(ld_idx_q - LD_A);
  assign a_in_rng = {1'b0, a_addr_in} < A_LIM;
  assign b_in_rng = {1'b0, b_addr_in} < B_LIM;
  assign c_in_rng = {1'b0, c_addr_in} < C_LIM;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= LOAD;
      ld_idx_q     <= '0;
      dr_idx_q     <= '0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_idx_q     <= ld_idx_d;
      dr_idx_q     <= dr_idx_d;
      drain_done_q <= drain_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ld_idx_d     = ld_idx_q;
    dr_idx_d     = dr_idx_q;
    drain_done_d = 1'b0;
    load_ready   = 1'b0;
    mac_compute  = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    case (state_q)
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          if (ld_idx_q == LD_LAST) begin
            ld_idx_d = '0;
            state_d  = READY;
          end else begin
            ld_idx_d = ld_idx_q + 1'b1;
          end
        end
      end
      READY: begin
        if (start) state_d = COMPUTE;
      end
      COMPUTE: begin
        mac_compute = 1'b1;
        if (mac_done) state_d = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = c_mem[dr_idx_q];
        if (out_ready) begin
          if (dr_idx_q == DR_LAST) begin
            dr_idx_d     = '0;
            drain_done_d = 1'b1;
            state_d      = LOAD;
          end else begin
            dr_idx_d = dr_idx_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Storage carries no reset so results survive a reset for inspection.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && load_valid) begin
      if (ld_idx_q < LD_A) a_mem[ld_a_idx] <= load_data;
      else                 b_mem[ld_b_idx] <= load_data;
    end
    if (state_q == COMPUTE && c_we && c_in_rng) c_mem[c_addr_in] <= c_data_in;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_data_q <= '0;
      b_data_q <= '0;
    end else if (a_b_re) begin
      a_data_q <= a_in_rng ? a_mem[a_addr_in] : '0;
      b_data_q <= b_in_rng ? b_mem[b_addr_in] : '0;
    end
  end

  assign a_data_out = a_data_q;
  assign b_data_out = b_data_q;
  assign drain_done = drain_done_q;

endmodule
